// File: rtl/wb_pkg.sv
// wb_pkg: shared types and widths for the regfile write-port arbiter
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO of writeback requests with per-slot valid and rd taps
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  wb_req_t                            din,
  output wb_req_t                            head,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]   rds
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wp, rp;
  wb_req_t mem [DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        wp        <= wp + 1'b1;
        valid[wp] <= 1'b1;
      end
      if (pop) begin
        rp        <= rp + 1'b1;
        valid[rp] <= 1'b0;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign head = mem[rp];
  always_comb
    for (int i = 0; i < DEPTH; i++) rds[i] = mem[i].rd;
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline writeback and buffered aux results onto one regfile port
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_wen,
  input  logic [4:0]               pipe_rd,
  input  logic [XLEN-1:0]          pipe_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_rd,
  input  logic [XLEN-1:0]          aux_data,
  output logic                     regWEn,
  output logic [4:0]               rsW,
  output logic [XLEN-1:0]          data_W,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  import wb_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic prim, push, pop;
  wb_req_t head;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0][4:0] rds;
  assign aux_ready = (fifo_count < CW'(DEPTH)) && !reset;
  assign prim = pipe_wen && pipe_rd != 5'd0;
  assign push = aux_valid && aux_ready && aux_rd != 5'd0;
  assign pop  = !prim && fifo_count != '0;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ('{rd: aux_rd, data: aux_data}),
    .head  (head),
    .count (fifo_count),
    .valid (valid),
    .rds   (rds)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      regWEn <= 1'b0;
      rsW    <= '0;
      data_W <= '0;
    end else begin
      regWEn <= prim || pop;
      rsW    <= prim ? pipe_rd : pop ? head.rd : '0;
      data_W <= prim ? pipe_data : pop ? head.data : '0;
    end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) pend_mask[rds[i]] = 1'b1;
    if (regWEn) pend_mask[rsW] = 1'b1;
    pend_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vector table, reset sequence and randomized queue-model check
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic pipe_wen, aux_valid, aux_ready, regWEn;
  logic [4:0] pipe_rd, aux_rd, rsW;
  logic [31:0] pipe_data, aux_data, data_W, pend_mask;
  logic [2:0] fifo_count;
  int total = 0, bad = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .regWEn(regWEn), .rsW(rsW), .data_W(data_W), .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pw; logic [4:0] prd; logic [31:0] pd;
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic ew; logic [4:0] ers; logic [31:0] ed; int ec; logic [31:0] em; logic erdy;
  } vec_t;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

  vec_t tv[19];
  ent_t q[$];
  logic mw;
  logic [4:0] mrs;
  logic [31:0] md;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    pipe_wen = pw; pipe_rd = prd; pipe_data = pd;
    aux_valid = av; aux_rd = ard; aux_data = ad;
  endtask

  function automatic vec_t mk(logic pw, logic [4:0] prd, logic [31:0] pd, logic av, logic [4:0] ard,
                              logic [31:0] ad, logic ew, logic [4:0] ers, logic [31:0] ed, int ec,
                              logic [31:0] em, logic erdy);
    vec_t v;
    v.pw = pw; v.prd = prd; v.pd = pd; v.av = av; v.ard = ard; v.ad = ad;
    v.ew = ew; v.ers = ers; v.ed = ed; v.ec = ec; v.em = em; v.erdy = erdy;
    return v;
  endfunction

  function automatic logic [31:0] bit_of(int r);
    return 32'(1) << r;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (mw) m[mrs] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_outputs(input string tag, input logic w, input logic [4:0] r, input logic [31:0] d,
                               input int c, input logic [31:0] m, input logic rdy);
    chk({tag, ".regWEn"}, 64'(regWEn), 64'(w));
    chk({tag, ".rsW"}, 64'(rsW), 64'(r));
    chk({tag, ".data_W"}, 64'(data_W), 64'(d));
    chk({tag, ".fifo_count"}, 64'(fifo_count), 64'(c));
    chk({tag, ".pend_mask"}, 64'(pend_mask), 64'(m));
    chk({tag, ".aux_ready"}, 64'(aux_ready), 64'(rdy));
  endtask

  initial begin
    tv[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,   1, 5, 32'hDEADBEEF, 0, bit_of(5), 1);
    tv[1]  = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 1);
    tv[2]  = mk(0, 0, 0, 1, 7, 32'h12,          0, 0, 0, 1, bit_of(7), 1);
    tv[3]  = mk(0, 0, 0, 0, 0, 0,               1, 7, 32'h12, 0, bit_of(7), 1);
    tv[4]  = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 1);
    tv[5]  = mk(1, 1, 1, 1, 10, 32'hA,          1, 1, 1, 1, bit_of(1) | bit_of(10), 1);
    tv[6]  = mk(1, 2, 2, 1, 11, 32'hB,          1, 2, 2, 2, bit_of(2) | bit_of(10) | bit_of(11), 1);
    tv[7]  = mk(1, 3, 3, 1, 12, 32'hC,          1, 3, 3, 3, bit_of(3) | bit_of(10) | bit_of(11) | bit_of(12), 1);
    tv[8]  = mk(1, 4, 4, 1, 13, 32'hD,          1, 4, 4, 4, bit_of(4) | bit_of(10) | bit_of(11) | bit_of(12) | bit_of(13), 0);
    tv[9]  = mk(1, 6, 6, 1, 14, 32'hE,          1, 6, 6, 4, bit_of(6) | bit_of(10) | bit_of(11) | bit_of(12) | bit_of(13), 0);
    tv[10] = mk(0, 0, 0, 0, 0, 0,               1, 10, 32'hA, 3, bit_of(10) | bit_of(11) | bit_of(12) | bit_of(13), 1);
    tv[11] = mk(0, 0, 0, 1, 15, 32'hF,          1, 11, 32'hB, 3, bit_of(11) | bit_of(12) | bit_of(13) | bit_of(15), 1);
    tv[12] = mk(0, 0, 0, 0, 0, 0,               1, 12, 32'hC, 2, bit_of(12) | bit_of(13) | bit_of(15), 1);
    tv[13] = mk(0, 0, 0, 0, 0, 0,               1, 13, 32'hD, 1, bit_of(13) | bit_of(15), 1);
    tv[14] = mk(0, 0, 0, 0, 0, 0,               1, 15, 32'hF, 0, bit_of(15), 1);
    tv[15] = mk(1, 0, 32'h99, 1, 0, 32'h77,     0, 0, 0, 0, 0, 1);
    tv[16] = mk(1, 0, 32'h55, 1, 20, 32'h20,    0, 0, 0, 1, bit_of(20), 1);
    tv[17] = mk(1, 0, 32'h5, 0, 0, 0,           1, 20, 32'h20, 0, bit_of(20), 1);
    tv[18] = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 1);

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    reset = 0;
    for (int i = 0; i < 19; i++) begin
      drive(tv[i].pw, tv[i].prd, tv[i].pd, tv[i].av, tv[i].ard, tv[i].ad);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), tv[i].ew, tv[i].ers, tv[i].ed, tv[i].ec, tv[i].em, tv[i].erdy);
    end

    // buffer two aux entries behind pipeline writes, then reset asynchronously
    drive(1, 1, 32'h111, 1, 8, 32'h888);
    @(negedge clk);
    drive(1, 2, 32'h222, 1, 9, 32'h999);
    @(negedge clk);
    chk("pre_rst.fifo_count", 64'(fifo_count), 64'd2);
    chk("pre_rst.regWEn", 64'(regWEn), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("post_rst.aux_ready", 64'(aux_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outputs($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0, 1);
    end

    q.delete();
    mw = 0; mrs = 0; md = 0;
    for (int c = 0; c < 600; c++) begin
      logic pw, av, acc, prim;
      logic [4:0] prd, ard;
      logic [31:0] pd, ad;
      ent_t e;
      pw  = ($urandom_range(0, 99) < (c < 300 ? 70 : 30));
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pd  = $urandom;
      av  = $urandom_range(0, 1) == 1;
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ad  = $urandom;
      drive(pw, prd, pd, av, ard, ad);
      #1;
      chk($sformatf("rnd%0d.aux_ready", c), 64'(aux_ready), 64'(q.size() < DEPTH));
      acc  = av && q.size() < DEPTH;
      prim = pw && prd != 0;
      if (prim) begin
        mw = 1; mrs = prd; md = pd;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        mw = 1; mrs = e.rd; md = e.d;
      end else begin
        mw = 0; mrs = 0; md = 0;
      end
      if (acc && ard != 0) q.push_back('{rd: ard, d: ad});
      @(negedge clk);
      chk($sformatf("rnd%0d.regWEn", c), 64'(regWEn), 64'(mw));
      chk($sformatf("rnd%0d.rsW", c), 64'(rsW), 64'(mrs));
      chk($sformatf("rnd%0d.data_W", c), 64'(data_W), 64'(md));
      chk($sformatf("rnd%0d.fifo_count", c), 64'(fifo_count), 64'(q.size()));
      chk($sformatf("rnd%0d.pend_mask", c), 64'(pend_mask), 64'(model_mask()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
